// File: rtl/display_driver.sv
// rtl/display_driver.sv - four-digit multiplexed seven-segment driver with frame-atomic display updates.
module display_driver #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_lsb,
  input  logic [7:0] data_msb,
  input  logic       load,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   display;
  logic          pending;

  logic          tick;
  logic          commit;
  logic [3:0]    nibble;
  logic          blank;
  logic [6:0]    seg_next;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  endfunction

  assign tick   = (presc == PRESC_LAST);
  assign commit = tick && (idx == 2'd3);

  // Decode always uses the committed display value, never the shadow.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    case (idx)
      2'd0: nibble = display[3:0];
      2'd1: nibble = display[7:4];
      2'd2: nibble = display[11:8];
      default: nibble = display[15:12];
    endcase
    if (BLANK_LZ) begin
      case (idx)
        2'd1:    blank = (display[15:4] == 12'h000);
        2'd2:    blank = (display[15:8] == 8'h00);
        2'd3:    blank = (display[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end
    seg_next = blank ? 7'b1111111 : hex_seg(nibble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      idx   <= 2'd0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 2'd1;
    end
  end

  // A load coinciding with the commit goes straight to the display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= 16'h0000;
      display <= 16'h0000;
      pending <= 1'b0;
    end else if (commit) begin
      if (load) begin
        display <= {data_msb, data_lsb};
        shadow  <= {data_msb, data_lsb};
      end else if (pending) begin
        display <= shadow;
      end
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= {data_msb, data_lsb};
      pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= 7'b1000000;
      an         <= 4'b1110;
      frame_done <= 1'b0;
    end else begin
      seg        <= seg_next;
      an         <= ~(4'b0001 << idx);
      frame_done <= commit;
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// tb/tb_display_driver.sv - self-checking bench for display_driver, both blanking modes side by side.
module tb_display_driver;

  localparam int DIV = 4;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, SE = 7'b0000110, SF = 7'b0001110;
  localparam logic [6:0] SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110, SD = 7'b0100001;
  localparam logic [6:0] BL = 7'b1111111;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [7:0] data_lsb = 8'h00;
  logic [7:0] data_msb = 8'h00;
  logic [6:0] seg0, seg1;
  logic [3:0] an0, an1;
  logic       fd0, fd1;

  int checks = 0;
  int errors = 0;

  display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .data_lsb(data_lsb), .data_msb(data_msb), .load(load),
    .seg(seg0), .an(an0), .frame_done(fd0)
  );

  display_driver #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .data_lsb(data_lsb), .data_msb(data_msb), .load(load),
    .seg(seg1), .an(an1), .frame_done(fd1)
  );

  always #5 if (clk_en) clk = ~clk;

  // Reference model: time is a count of edges since reset; digit and frame follow by division.
  logic [6:0]  seg_tab [16];
  int          n;
  logic [15:0] m_disp, m_shadow;
  bit          m_pend;
  logic [6:0]  e_seg0, e_seg1;
  logic [3:0]  e_an;
  logic        e_fd;

  function automatic logic [6:0] seg_from_letters(string s);
    logic [6:0] r;
    r = 7'h7f;
    for (int k = 0; k < s.len(); k++) begin
      int p;
      p = int'(s[k]) - 97;
      r[p] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic [6:0] digit_seg(logic [15:0] v, int i, bit blz);
    logic [15:0] upper;
    upper = v >> (4 * i);
    if (blz && i > 0 && upper == 16'h0000) return BL;
    return seg_tab[int'(upper & 16'h000f)];
  endfunction

  task automatic model_reset();
    n = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0;
    e_an = 4'b1110; e_seg0 = seg_tab[0]; e_seg1 = seg_tab[0]; e_fd = 1'b0;
  endtask

  task automatic model_edge(logic l, logic [15:0] d);
    int pidx;
    n = n + 1;
    pidx = ((n - 1) / DIV) % 4;
    e_an = ~(4'b0001 << pidx);
    e_seg0 = digit_seg(m_disp, pidx, 1'b0);
    e_seg1 = digit_seg(m_disp, pidx, 1'b1);
    e_fd = (n % (4 * DIV)) == 0;
    if (e_fd) begin
      if (l) begin m_disp = d; m_shadow = d; end
      else if (m_pend) m_disp = m_shadow;
      m_pend = 1'b0;
    end else if (l) begin
      m_shadow = d; m_pend = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("out_full",  32'({seg0, an0, fd0}), 32'({e_seg0, e_an, e_fd}));
    chk("out_blank", 32'({seg1, an1, fd1}), 32'({e_seg1, e_an, e_fd}));
  endtask

  task automatic step();
    logic l, r;
    logic [15:0] d;
    @(posedge clk);
    l = load; r = rst; d = {data_msb, data_lsb};
    @(negedge clk);
    if (r) model_reset();
    else model_edge(l, d);
    compare();
  endtask

  task automatic wait_frame(string name);
    int k;
    k = 0;
    while (!fd0 && k < 40) begin step(); k++; end
    chk(name, 32'(fd0), 32'd1);
  endtask

  // Called right after a frame_done sample: checks the next full frame against constants.
  task automatic check_frame(string name, logic [27:0] full, logic [27:0] blank);
    for (int dg = 0; dg < 4; dg++) begin
      for (int c = 0; c < DIV; c++) begin
        step();
        chk({name, "_full"},  32'({an0, seg0}), 32'({~(4'b0001 << dg), full[dg*7 +: 7]}));
        chk({name, "_blank"}, 32'({an1, seg1}), 32'({~(4'b0001 << dg), blank[dg*7 +: 7]}));
      end
    end
  endtask

  task automatic drive(logic [15:0] v);
    load = 1'b1; data_msb = v[15:8]; data_lsb = v[7:0];
  endtask

  typedef struct {
    logic [15:0] val;
    logic [27:0] full;
    logic [27:0] blank;
  } vec_t;

  initial begin
    vec_t tbl [6];
    string lit [16];
    int ones, k;

    lit = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};
    for (int i = 0; i < 16; i++) seg_tab[i] = seg_from_letters(lit[i]);

    tbl[0] = '{16'h1234, {S1, S2, S3, S4}, {S1, S2, S3, S4}};
    tbl[1] = '{16'h0005, {S0, S0, S0, S5}, {BL, BL, BL, S5}};
    tbl[2] = '{16'hABCD, {SA, SB, SC, SD}, {SA, SB, SC, SD}};
    tbl[3] = '{16'h0F0F, {S0, SF, S0, SF}, {BL, SF, S0, SF}};
    tbl[4] = '{16'h0000, {S0, S0, S0, S0}, {BL, BL, BL, S0}};
    tbl[5] = '{16'h00E0, {S0, S0, SE, S0}, {BL, BL, SE, S0}};

    // Reset with the clock stopped.
    #1 rst = 1'b1;
    #1 model_reset();
    chk("reset_noclk_full",  32'({seg0, an0, fd0}), 32'({S0, 4'b1110, 1'b0}));
    chk("reset_noclk_blank", 32'({seg1, an1, fd1}), 32'({S0, 4'b1110, 1'b0}));
    clk_en = 1'b1;
    step(); step();
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      drive(tbl[v].val);
      step();
      load = 1'b0;
      wait_frame("vec_frame");
      check_frame("vec", tbl[v].full, tbl[v].blank);
    end

    // Last load wins; the intermediate value never reaches the digits.
    drive(16'h1111); step();
    load = 1'b0;     step();
    drive(16'hABCD); step();
    load = 1'b0;
    ones = 0; k = 0;
    while (!fd0 && k < 40) begin
      step(); k++;
      if (seg0 == S1 || seg1 == S1) ones++;
    end
    chk("last_wins_frame", 32'(fd0), 32'd1);
    chk("last_wins_no_1111", 32'(ones), 32'd0);
    check_frame("last_wins", {SA, SB, SC, SD}, {SA, SB, SC, SD});

    // Load landing exactly on the commit edge.
    for (int i = 0; i < 4 * DIV - 1; i++) step();
    drive(16'h0F0F);
    step();
    load = 1'b0;
    chk("commit_load_fd", 32'(fd0), 32'd1);
    chk("commit_load_pending", 32'(dut0.pending), 32'd0);
    check_frame("commit_load", {S0, SF, S0, SF}, {BL, SF, S0, SF});
    chk("commit_load_pending_after", 32'(dut1.pending), 32'd0);

    // Reset mid-frame with a load pending.
    drive(16'h7777); step();
    load = 1'b0;
    k = 0;
    while (an0 != 4'b1011 && k < 20) begin step(); k++; end
    chk("midrst_at_idx2", 32'(an0), 32'(4'b1011));
    rst = 1'b1;
    #1 model_reset();
    chk("midrst_async", 32'({seg0, an0, fd0, seg1}), 32'({S0, 4'b1110, 1'b0, S0}));
    compare();
    step(); step();
    rst = 1'b0;
    chk("midrst_pending", 32'(dut0.pending), 32'd0);
    wait_frame("midrst_frame");
    check_frame("midrst", {S0, S0, S0, S0}, {BL, BL, BL, S0});

    // Randomized loads, checked every cycle against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [15:0] rv;
        rv = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 3)));
        drive(rv);
      end else begin
        load = 1'b0;
      end
      step();
    end
    load = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
